// File: rtl/holy_irq_conditioner.sv
// Interrupt front-end: per-source polarity fix, 2-FF synchronizer, stability filter,
// level/edge selection with sticky edge capture, software clear and overrun flag.
module holy_irq_conditioner #(
    parameter int                  NUM_IRQS      = 5,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [NUM_IRQS-1:0] ACTIVE_LOW    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQS-1:0] irq_raw,
    input  logic [NUM_IRQS-1:0] edge_mode,
    input  logic [NUM_IRQS-1:0] irq_clr,
    output logic [NUM_IRQS-1:0] irq_out,
    output logic [NUM_IRQS-1:0] irq_filt,
    output logic [NUM_IRQS-1:0] irq_overrun
);

    localparam int              CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic [NUM_IRQS-1:0]            a;
    logic [NUM_IRQS-1:0]            s1, s2;
    logic [NUM_IRQS-1:0]            filt, filt_nxt;
    logic [NUM_IRQS-1:0][CNT_W-1:0] cnt, cnt_nxt;
    logic [NUM_IRQS-1:0]            rise;
    logic [NUM_IRQS-1:0]            pending, pending_nxt;
    logic [NUM_IRQS-1:0]            overrun, overrun_nxt;

    assign a = irq_raw ^ ACTIVE_LOW;

    // A source only commits a new level after s2 has differed from filt for
    // FILTER_CYCLES consecutive cycles; returning to filt restarts the count.
    always_comb begin
        filt_nxt = filt;
        cnt_nxt  = cnt;
        rise     = '0;
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (s2[i] == filt[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                filt_nxt[i] = s2[i];
                cnt_nxt[i]  = '0;
                rise[i]     = s2[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Rise beats a simultaneous clear; level-mode sources hold no edge state.
    assign pending_nxt = edge_mode & (rise | (pending & ~irq_clr));
    assign overrun_nxt = edge_mode & ((rise & pending & ~irq_clr) | (overrun & ~irq_clr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sync flops reset to 0 as well, so an idle active-low line reads deasserted.
            s1      <= '0;
            s2      <= '0;
            filt    <= '0;
            cnt     <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples the previous cycle's value.
            s1      <= a;
            s2      <= s1;
            filt    <= filt_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
        end
    end

    assign irq_out     = (edge_mode & pending) | (~edge_mode & filt);
    assign irq_filt    = filt;
    assign irq_overrun = overrun;

endmodule
